fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Next-generation synchronous FIFO for the adder datapath.
- Generalises the fixed 8x8 show-ahead FIFO to arbitrary width and depth (non-power-of-two allowed).
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between operand producers and the adder core as the standard elastic buffer.

Parameters:
- DATAW, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AF_THR, 6, almost_full asserts when occupancy >= AF_THR (1..DEPTH).
- AE_THR, 2, almost_empty asserts when occupancy <= AE_THR (0..DEPTH-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- w  in  1  write request.
- r  in  1  read/pop request.
- data_in  in  DATAW  write data.
- clr_err  in  1  clears sticky error flags.
- data_out  out  DATAW  head-of-queue data (show-ahead); 0 when empty.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= AF_THR.
- almost_empty  out  1  occupancy <= AE_THR.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Read and write pointers = 0; occupancy = 0.
  - overflow = underflow = 0.
  - Memory contents are not cleared.
  - After reset: empty=1, full=0, almost_empty=1, almost_full=0 (given AF_THR>=1), data_out=0.
  - Reset has priority over all other inputs; a reset mid-stream discards all entries.
- Show-ahead read port:
  - data_out = mem[rd_ptr] combinationally from registered state whenever empty=0; 0 when empty=1.
  - Zero-latency: a word written at edge N is visible on data_out after edge N when the FIFO was empty.
- Acceptance:
  - wr_ok = w & ~full (without the optional feature).
  - rd_ok = r & ~empty.
  - On wr_ok: mem[wr_ptr] <= data_in; wr_ptr advances.
  - On rd_ok: rd_ptr advances; data_out shows the next entry after the edge.
- Pointer wrap: a pointer at DEPTH-1 advances to 0; explicit compare, no reliance on power-of-two overflow.
- Occupancy:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Simultaneous events:
  - Full with w=1, r=1: the read pops; the write is rejected (baseline).
  - Empty with w=1, r=1: the write is accepted; the read is rejected; the new word appears on data_out next cycle.
  - Neither full nor empty with w=1, r=1: both proceed; occupancy is unchanged.
- Flags: full, empty, almost_full, almost_empty are pure decodes of registered occupancy and change only after a clock edge.
- Error flags:
  - overflow sets on any edge with w=1 & ~wr_ok.
  - underflow sets on any edge with r=1 & empty=1.
  - Both hold until clr_err=1 or rst.
  - If clr_err and a new error occur at the same edge, set wins.
  - A rejected access has no other side effect.

Optional Feature:
- Macro: FIFO_FULL_PASSTHRU_EN.
- Defined: when full and w=1, r=1 on the same edge, both the pop and the write are accepted.
  - The written word lands in the slot freed by the pop; occupancy stays DEPTH.
  - overflow is not set.
  - wr_ok = w & (~full | r).
- Not defined: baseline behaviour; the write is rejected, occupancy drops to DEPTH-1, and overflow sets.

Test Plan:
- Reset, write 1..8 (DEPTH=8) -> full=1, occupancy=8, almost_full=1 from the 6th write, data_out=1 throughout.
- From full, read 3 -> data_out steps 2,3,4; occupancy=5; full=0; almost_full=0 at occupancy 5.
- Full FIFO, w=1 r=1 with data_in=9, baseline build:
  - Occupancy becomes 7 and overflow=1.
  - Draining yields 2..8 with no 9 present.
  - With FIFO_FULL_PASSTHRU_EN: occupancy stays 8, overflow=0, and draining yields 2..8 then 9.
- Empty FIFO, r=1 w=1 data_in=2 -> underflow=1, occupancy=1, data_out=2 the next cycle; clr_err -> underflow=0.
- DEPTH=5 build: write 1..5, read 3, write 6..8, read 5 -> output order 1..8 across pointer wrap; empty=1 at end.
- rst asserted while occupancy=4 -> next cycle occupancy=0, empty=1, data_out=0, error flags=0.

Source files
------------

// File: rtl/fifo_param.sv
// fifo_param: parameterised show-ahead synchronous FIFO with occupancy count, almost flags and sticky errors.
// Define FIFO_FULL_PASSTHRU_EN to accept a write into a full FIFO when a pop happens on the same edge.
module fifo_param #(
  parameter int unsigned DATAW  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AF_THR = 6,
  parameter int unsigned AE_THR = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w,
  input  logic                         r,
  input  logic [DATAW-1:0]             data_in,
  input  logic                         clr_err,
  output logic [DATAW-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Flags are pure decodes of the registered count
  assign full         = (occ_q == OW'(DEPTH));
  assign empty        = (occ_q == '0);
  assign almost_full  = (occ_q >= OW'(AF_THR));
  assign almost_empty = (occ_q <= OW'(AE_THR));
  assign occupancy    = occ_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign data_out     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ok = r & ~empty;
`ifdef FIFO_FULL_PASSTHRU_EN
    wr_ok = w & (~full | r);
`else
    wr_ok = w & ~full;
`endif
  end

  // Next-state: pointers wrap by explicit compare so DEPTH need not be a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    // A new error on the same edge as clr_err wins
    ovf_d = (w & ~wr_ok) | (ovf_q & ~clr_err);
    udf_d = (r & ~rd_ok) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: drives a DEPTH=8 and a DEPTH=5 fifo_param with shared stimulus; scoreboard against a history-array model.
module tb_fifo_param;

`ifdef FIFO_FULL_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w = 1'b0;
  logic       r = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout8, dout5;
  logic       full8, empty8, af8, ae8, ovf8, udf8;
  logic       full5, empty5, af5, ae5, ovf5, udf5;
  logic [3:0] occ8;
  logic [2:0] occ5;

  fifo_param #(.DATAW(8), .DEPTH(8), .AF_THR(6), .AE_THR(2)) u_fifo8 (
    .clk(clk), .rst(rst), .w(w), .r(r), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout8), .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
    .occupancy(occ8), .overflow(ovf8), .underflow(udf8)
  );

  fifo_param #(.DATAW(8), .DEPTH(5), .AF_THR(4), .AE_THR(1)) u_fifo5 (
    .clk(clk), .rst(rst), .w(w), .r(r), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout5), .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .occupancy(occ5), .overflow(ovf5), .underflow(udf5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every accepted word is appended to an unbounded history; contents are hist[hr..hw-1]
  logic [7:0]  hist [2][4096];
  logic [31:0] hw [2];
  logic [31:0] hr [2];
  bit          ovf_m [2];
  bit          udf_m [2];
  bit          known = 1'b0;

  typedef struct packed {
    logic        known;
    logic [31:0] occ0, occ1, head0, head1;
    logic        ovf0, ovf1, udf0, udf1;
  } rec_t;

  rec_t       st_q [$];
  logic [7:0] out_q0 [$];
  logic [7:0] out_q1 [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_of(input int k);
    if (hw[k] == hr[k]) return 32'd0;
    return 32'(hist[k][hr[k][11:0]]);
  endfunction

  task automatic cyc(input bit wi, input bit ri, input logic [7:0] di, input bit ci, input bit rsti);
    rec_t rc;
    int   dp, occ;
    bit   full_m, empty_m, rd_ok, wr_ok;
    @(posedge clk);
    #1;
    w = wi; r = ri; data_in = di; clr_err = ci; rst = rsti;
    rc.known = known;
    rc.occ0  = hw[0] - hr[0];
    rc.occ1  = hw[1] - hr[1];
    rc.head0 = head_of(0);
    rc.head1 = head_of(1);
    rc.ovf0  = ovf_m[0];
    rc.ovf1  = ovf_m[1];
    rc.udf0  = udf_m[0];
    rc.udf1  = udf_m[1];
    st_q.push_back(rc);
    for (int k = 0; k < 2; k++) begin
      dp  = (k == 0) ? 8 : 5;
      occ = int'(hw[k] - hr[k]);
      if (rsti) begin
        hr[k]    = hw[k];
        ovf_m[k] = 1'b0;
        udf_m[k] = 1'b0;
      end else begin
        full_m  = (occ == dp);
        empty_m = (occ == 0);
        rd_ok   = ri && !empty_m;
        wr_ok   = wi && (!full_m || (PT && ri));
        if (rd_ok) begin
          if (k == 0) out_q0.push_back(hist[k][hr[k][11:0]]);
          else        out_q1.push_back(hist[k][hr[k][11:0]]);
          hr[k] = hr[k] + 1;
        end
        if (wr_ok) begin
          hist[k][hw[k][11:0]] = di;
          hw[k] = hw[k] + 1;
        end
        ovf_m[k] = (wi && !wr_ok) ? 1'b1 : (ci ? 1'b0 : ovf_m[k]);
        udf_m[k] = (ri && empty_m) ? 1'b1 : (ci ? 1'b0 : udf_m[k]);
      end
    end
    if (rsti) known = 1'b1;
  endtask

  // Monitor: compares visible state each cycle and pops the scoreboard whenever a DUT pops
  always @(negedge clk) begin
    rec_t rc;
    if (st_q.size() > 0) begin
      rc = st_q.pop_front();
      if (rc.known) begin
        chk("occ8",   int'(occ8),   int'(rc.occ0));
        chk("full8",  int'(full8),  int'(rc.occ0 == 8));
        chk("empty8", int'(empty8), int'(rc.occ0 == 0));
        chk("af8",    int'(af8),    int'(rc.occ0 >= 6));
        chk("ae8",    int'(ae8),    int'(rc.occ0 <= 2));
        chk("ovf8",   int'(ovf8),   int'(rc.ovf0));
        chk("udf8",   int'(udf8),   int'(rc.udf0));
        chk("head8",  int'(dout8),  int'(rc.head0));
        chk("occ5",   int'(occ5),   int'(rc.occ1));
        chk("full5",  int'(full5),  int'(rc.occ1 == 5));
        chk("empty5", int'(empty5), int'(rc.occ1 == 0));
        chk("af5",    int'(af5),    int'(rc.occ1 >= 4));
        chk("ae5",    int'(ae5),    int'(rc.occ1 <= 1));
        chk("ovf5",   int'(ovf5),   int'(rc.ovf1));
        chk("udf5",   int'(udf5),   int'(rc.udf1));
        chk("head5",  int'(dout5),  int'(rc.head1));
        if (r && !rst && !empty8) begin
          if (out_q0.size() == 0) chk("pop8_unexpected", 1, 0);
          else chk("pop8", int'(dout8), int'(out_q0.pop_front()));
        end
        if (r && !rst && !empty5) begin
          if (out_q1.size() == 0) chk("pop5_unexpected", 1, 0);
          else chk("pop5", int'(dout5), int'(out_q1.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    for (int k = 0; k < 2; k++) begin
      hw[k] = 0; hr[k] = 0; ovf_m[k] = 1'b0; udf_m[k] = 1'b0;
    end
    cyc(0, 0, 8'd0, 0, 1);
    cyc(0, 0, 8'd0, 0, 1);
    // Fill to full, then pop three
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'd0, 0, 0);
    cyc(0, 0, 8'd0, 0, 0);
    // Full with simultaneous write and read of 9, then drain
    cyc(0, 0, 8'd0, 0, 1);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
    cyc(1, 1, 8'd9, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'd0, 0, 0);
    // Empty with simultaneous write and read, then clear errors
    cyc(0, 0, 8'd0, 1, 0);
    cyc(1, 1, 8'd2, 0, 0);
    cyc(0, 0, 8'd0, 0, 0);
    cyc(0, 0, 8'd0, 1, 0);
    cyc(0, 0, 8'd0, 0, 0);
    // Reset mid-stream
    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i + 16), 0, 0);
    cyc(0, 0, 8'd0, 0, 1);
    cyc(0, 0, 8'd0, 0, 0);
    // Pointer wrap sequence
    for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'd0, 0, 0);
    for (int i = 6; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'd0, 0, 0);
    cyc(0, 0, 8'd0, 0, 0);
    // Randomized segments with varying write bias
    for (int seg = 0; seg < 8; seg++) begin
      pw = (seg % 4 == 0) ? 85 : (seg % 4 == 1) ? 15 : (seg % 4 == 2) ? 55 : 45;
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (110 - pw),
            8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end
    end
    cyc(0, 0, 8'd0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
